// File: rtl/exers_sched.sv
// exers_sched: reservation station and oldest-first issue scheduler for the integer ALU.
// Holds renamed ops until both operands are ready, snoops the CDB to wake waiting
// operands, and issues through a registered valid/stall handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rename_exers_write, rename_*  dispatch write interface (operand = value or tag in [6:0])
//   exers_stall                   station full, write refused
//   cdb_valid/robid/result        common data bus broadcast
//   alu_stall                     ALU cannot take the issue register this cycle
//   issue_*                       issue register contents
//   rob_flush                     discard every in-flight op
module exers_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rename_exers_write,
  input  logic [4:0]  rename_op,
  input  logic [6:0]  rename_robid,
  input  logic [5:0]  rename_rd,
  input  logic        rename_op1ready,
  input  logic [31:0] rename_op1,
  input  logic        rename_op2ready,
  input  logic [31:0] rename_op2,
  input  logic [31:0] rename_imm,
  output logic        exers_stall,
  input  logic        cdb_valid,
  input  logic [6:0]  cdb_robid,
  input  logic [31:0] cdb_result,
  input  logic        alu_stall,
  output logic        issue_valid,
  output logic [4:0]  issue_op,
  output logic [6:0]  issue_robid,
  output logic [5:0]  issue_rd,
  output logic [31:0] issue_op1,
  output logic [31:0] issue_op2,
  output logic [31:0] issue_imm,
  input  logic        rob_flush
);

  logic [DEPTH-1:0] valid_q, r1_q, r2_q;
  logic [4:0]       op_q    [DEPTH];
  logic [6:0]       robid_q [DEPTH];
  logic [5:0]       rd_q    [DEPTH];
  logic [31:0]      v1_q    [DEPTH];
  logic [31:0]      v2_q    [DEPTH];
  logic [31:0]      imm_q   [DEPTH];
  // age_q[i][j] = 1: entry i is older than entry j
  logic [DEPTH-1:0] age_q   [DEPTH];

  logic             issue_valid_q;
  logic [4:0]       issue_op_q;
  logic [6:0]       issue_robid_q;
  logic [5:0]       issue_rd_q;
  logic [31:0]      issue_op1_q, issue_op2_q, issue_imm_q;

  logic             wr_en;
  logic [IDXW-1:0]  free_idx;
  logic             free_found;
  logic [DEPTH-1:0] eligible, pick_vec;
  logic             blocked;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any, can_load, do_issue;
  logic             in_hit1, in_hit2, in_r1, in_r2;
  logic [31:0]      in_v1, in_v2;

  // Full depends only on registered valid bits, so a slot freed this edge opens next cycle.
  assign exers_stall = &valid_q;
  assign wr_en       = rename_exers_write && !exers_stall;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDXW'(i);
        free_found = 1'b1;
      end
    end
  end

  assign eligible = valid_q & r1_q & r2_q;

  // Oldest-first: an eligible entry wins when no other eligible entry is older.
  always_comb begin
    pick_vec = '0;
    blocked  = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      blocked = 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (eligible[j] && age_q[j][i]) blocked = 1'b1;
      end
      pick_vec[i] = eligible[i] && !blocked;
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (pick_vec[i]) pick_idx = IDXW'(i);
    end
  end

  assign pick_any = |pick_vec;
  assign can_load = !issue_valid_q || !alu_stall;
  assign do_issue = can_load && pick_any;

  // Write-cycle bypass of a matching CDB broadcast.
  assign in_hit1 = !rename_op1ready && cdb_valid && (rename_op1[6:0] == cdb_robid);
  assign in_hit2 = !rename_op2ready && cdb_valid && (rename_op2[6:0] == cdb_robid);
  assign in_r1   = rename_op1ready || in_hit1;
  assign in_r2   = rename_op2ready || in_hit2;
  assign in_v1   = in_hit1 ? cdb_result : rename_op1;
  assign in_v2   = in_hit2 ? cdb_result : rename_op2;

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (cdb_valid && valid_q[i] && !(do_issue && pick_vec[i])) begin
          if (!r1_q[i] && (v1_q[i][6:0] == cdb_robid)) begin
            r1_q[i] <= 1'b1;
            v1_q[i] <= cdb_result;
          end
          if (!r2_q[i] && (v2_q[i][6:0] == cdb_robid)) begin
            r2_q[i] <= 1'b1;
            v2_q[i] <= cdb_result;
          end
        end
      end
      if (do_issue) valid_q[pick_idx] <= 1'b0;
      if (wr_en) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= rename_op;
        robid_q[free_idx] <= rename_robid;
        rd_q[free_idx]    <= rename_rd;
        r1_q[free_idx]    <= in_r1;
        v1_q[free_idx]    <= in_v1;
        r2_q[free_idx]    <= in_r2;
        v2_q[free_idx]    <= in_v2;
        imm_q[free_idx]   <= rename_imm;
        age_q[free_idx]   <= '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (IDXW'(i) != free_idx) age_q[i][free_idx] <= valid_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_robid_q <= '0;
      issue_rd_q    <= '0;
      issue_op1_q   <= '0;
      issue_op2_q   <= '0;
      issue_imm_q   <= '0;
    end else if (can_load) begin
      issue_valid_q <= pick_any;
      if (pick_any) begin
        issue_op_q    <= op_q[pick_idx];
        issue_robid_q <= robid_q[pick_idx];
        issue_rd_q    <= rd_q[pick_idx];
        issue_op1_q   <= v1_q[pick_idx];
        issue_op2_q   <= v2_q[pick_idx];
        issue_imm_q   <= imm_q[pick_idx];
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_op    = issue_op_q;
  assign issue_robid = issue_robid_q;
  assign issue_rd    = issue_rd_q;
  assign issue_op1   = issue_op1_q;
  assign issue_op2   = issue_op2_q;
  assign issue_imm   = issue_imm_q;

endmodule

// File: tb/tb_exers_sched.sv
module tb_exers_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rename_exers_write = 1'b0;
  logic [4:0]  rename_op = '0;
  logic [6:0]  rename_robid = '0;
  logic [5:0]  rename_rd = '0;
  logic        rename_op1ready = 1'b0;
  logic [31:0] rename_op1 = '0;
  logic        rename_op2ready = 1'b0;
  logic [31:0] rename_op2 = '0;
  logic [31:0] rename_imm = '0;
  logic        exers_stall;
  logic        cdb_valid = 1'b0;
  logic [6:0]  cdb_robid = '0;
  logic [31:0] cdb_result = '0;
  logic        alu_stall = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_op;
  logic [6:0]  issue_robid;
  logic [5:0]  issue_rd;
  logic [31:0] issue_op1, issue_op2, issue_imm;
  logic        rob_flush = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
  } exp_t;

  exp_t sb_q[$];

  exers_sched #(.DEPTH(8), .IDXW(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .rename_exers_write (rename_exers_write),
    .rename_op          (rename_op),
    .rename_robid       (rename_robid),
    .rename_rd          (rename_rd),
    .rename_op1ready    (rename_op1ready),
    .rename_op1         (rename_op1),
    .rename_op2ready    (rename_op2ready),
    .rename_op2         (rename_op2),
    .rename_imm         (rename_imm),
    .exers_stall        (exers_stall),
    .cdb_valid          (cdb_valid),
    .cdb_robid          (cdb_robid),
    .cdb_result         (cdb_result),
    .alu_stall          (alu_stall),
    .issue_valid        (issue_valid),
    .issue_op           (issue_op),
    .issue_robid        (issue_robid),
    .issue_rd           (issue_rd),
    .issue_op1          (issue_op1),
    .issue_op2          (issue_op2),
    .issue_imm          (issue_imm),
    .rob_flush          (rob_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic set_write(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                           input logic r1, input logic [31:0] v1, input logic r2,
                           input logic [31:0] v2, input logic [31:0] imm);
    rename_exers_write = 1'b1;
    rename_op = op; rename_robid = robid; rename_rd = rd;
    rename_op1ready = r1; rename_op1 = v1;
    rename_op2ready = r2; rename_op2 = v2;
    rename_imm = imm;
  endtask

  task automatic clr_write();
    rename_exers_write = 1'b0;
  endtask

  task automatic set_cdb(input logic [6:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_robid = tag; cdb_result = val;
  endtask

  task automatic clr_cdb();
    cdb_valid = 1'b0;
  endtask

  task automatic sb_push(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                         input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm);
    exp_t e;
    e.op = op; e.robid = robid; e.rd = rd; e.op1 = op1; e.op2 = op2; e.imm = imm;
    sb_q.push_back(e);
  endtask

  // Advance one clock; whenever the issue register was allowed to load and now holds an op,
  // that op must be the next one the scoreboard expects.
  task automatic step();
    logic load_ok;
    exp_t e;
    load_ok = (!issue_valid || !alu_stall) && !rst && !rob_flush;
    @(posedge clk);
    #1;
    if (load_ok && issue_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_issue: got robid=%0d required=no issue", issue_robid);
      end else begin
        e = sb_q.pop_front();
        if ({issue_op, issue_robid, issue_rd, issue_op1, issue_op2, issue_imm} !==
            {e.op, e.robid, e.rd, e.op1, e.op2, e.imm}) begin
          bad++;
          $display("FAIL sb_issue: got op=%0d robid=%0d rd=%0d op1=%h op2=%h imm=%h required op=%0d robid=%0d rd=%0d op1=%h op2=%h imm=%h",
                   issue_op, issue_robid, issue_rd, issue_op1, issue_op2, issue_imm,
                   e.op, e.robid, e.rd, e.op1, e.op2, e.imm);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (exers_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got=%b required=0", exers_stall); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required=0", issue_valid); end
    total++; if (issue_op !== 5'd0) begin bad++; $display("FAIL reset_op: got=%0d required=0", issue_op); end
    total++; if (issue_robid !== 7'd0) begin bad++; $display("FAIL reset_robid: got=%0d required=0", issue_robid); end
    total++; if ({issue_op1, issue_op2, issue_imm} !== 96'd0) begin bad++; $display("FAIL reset_data: got=%h required=0", {issue_op1, issue_op2, issue_imm}); end
  endtask

  task automatic test_basic();
    set_write(5'd3, 7'd5, 6'd1, 1'b1, 32'd10, 1'b1, 32'd20, 32'h77);
    sb_push(5'd3, 7'd5, 6'd1, 32'd10, 32'd20, 32'h77);
    step();
    clr_write();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL basic_not_yet: got=%b required=0", issue_valid); end
    step();
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got=%b required=1", issue_valid); end
    total++; if (issue_robid !== 7'd5) begin bad++; $display("FAIL basic_robid: got=%0d required=5", issue_robid); end
    total++; if ({issue_op1, issue_op2} !== {32'd10, 32'd20}) begin bad++; $display("FAIL basic_ops: got=%0d,%0d required=10,20", issue_op1, issue_op2); end
    step();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL basic_drop: got=%b required=0", issue_valid); end
  endtask

  task automatic test_wakeup();
    set_write(5'd4, 7'd9, 6'd2, 1'b0, 32'd4, 1'b1, 32'd1, 32'd0);
    sb_push(5'd4, 7'd9, 6'd2, 32'hDEAD, 32'd1, 32'd0);
    step();
    clr_write();
    set_cdb(7'd4, 32'hDEAD);
    step();
    clr_cdb();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_early: got=%b required=0", issue_valid); end
    step();
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL wake_valid: got=%b required=1", issue_valid); end
    total++; if (issue_op1 !== 32'hDEAD) begin bad++; $display("FAIL wake_op1: got=%h required=0000dead", issue_op1); end
    step();
    // Same-cycle bypass; tag bits above [6:0] are junk and must be ignored.
    set_write(5'd5, 7'd10, 6'd3, 1'b0, 32'hABCD_0084, 1'b1, 32'd2, 32'd5);
    set_cdb(7'd4, 32'hBEEF);
    sb_push(5'd5, 7'd10, 6'd3, 32'hBEEF, 32'd2, 32'd5);
    step();
    clr_write();
    clr_cdb();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL bypass_early: got=%b required=0", issue_valid); end
    step();
    total++; if ({issue_valid, issue_robid, issue_op1} !== {1'b1, 7'd10, 32'hBEEF}) begin bad++; $display("FAIL bypass_issue: got v=%b robid=%0d op1=%h required v=1 robid=10 op1=0000beef", issue_valid, issue_robid, issue_op1); end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_write(5'd1, 7'(20 + i), 6'(i), 1'b0, 32'hFFFF_FF80 | 32'(40 + i), 1'b1, 32'(i), 32'd0);
      step();
    end
    clr_write();
    total++; if (exers_stall !== 1'b1) begin bad++; $display("FAIL full_stall: got=%b required=1", exers_stall); end
    set_write(5'd2, 7'd28, 6'd8, 1'b1, 32'h28, 1'b1, 32'h29, 32'd0);
    set_cdb(7'd43, 32'h1043);
    sb_push(5'd1, 7'd23, 6'd3, 32'h1043, 32'd3, 32'd0);
    step();
    clr_cdb();
    total++; if (exers_stall !== 1'b1) begin bad++; $display("FAIL full_held: got=%b required=1", exers_stall); end
    step();
    total++; if (exers_stall !== 1'b0) begin bad++; $display("FAIL full_freed: got=%b required=0", exers_stall); end
    sb_push(5'd2, 7'd28, 6'd8, 32'h28, 32'h29, 32'd0);
    step();
    clr_write();
    total++; if (exers_stall !== 1'b1) begin bad++; $display("FAIL full_refill: got=%b required=1", exers_stall); end
    step();
    for (int t = 40; t < 48; t++) begin
      if (t != 43) begin
        set_cdb(7'(t), 32'h1000 + 32'(t));
        sb_push(5'd1, 7'(t - 20), 6'(t - 40), 32'h1000 + 32'(t), 32'(t - 40), 32'd0);
        step();
      end
    end
    clr_cdb();
    step();
    step();
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL full_drain: got pending=%0d required=0", sb_q.size()); end
  endtask

  task automatic test_oldest_first(input bit reverse);
    if (reverse) begin
      // Fillers in slots 0..2 freed 2,1,0 so robids 1,2,3 land in slots 2,1,0.
      for (int i = 0; i < 3; i++) begin
        set_write(5'd6, 7'(50 + i), 6'd0, 1'b0, 32'(60 + i), 1'b1, 32'd0, 32'd0);
        step();
      end
      clr_write();
      set_cdb(7'd62, 32'h62);
      sb_push(5'd6, 7'd52, 6'd0, 32'h62, 32'd0, 32'd0);
      step();
      clr_cdb();
      step();
      set_write(5'd7, 7'd1, 6'd11, 1'b0, 32'd7, 1'b1, 32'd0, 32'd0);
      set_cdb(7'd61, 32'h61);
      sb_push(5'd6, 7'd51, 6'd0, 32'h61, 32'd0, 32'd0);
      step();
      clr_write();
      clr_cdb();
      step();
      set_write(5'd7, 7'd2, 6'd12, 1'b0, 32'd7, 1'b1, 32'd0, 32'd0);
      set_cdb(7'd60, 32'h60);
      sb_push(5'd6, 7'd50, 6'd0, 32'h60, 32'd0, 32'd0);
      step();
      clr_write();
      clr_cdb();
      step();
      set_write(5'd7, 7'd3, 6'd13, 1'b0, 32'd7, 1'b1, 32'd0, 32'd0);
      step();
      clr_write();
    end else begin
      for (int i = 1; i <= 3; i++) begin
        set_write(5'd7, 7'(i), 6'(10 + i), 1'b0, 32'd7, 1'b1, 32'd0, 32'd0);
        step();
      end
      clr_write();
    end
    for (int i = 1; i <= 3; i++) sb_push(5'd7, 7'(i), 6'(10 + i), 32'hC0DE, 32'd0, 32'd0);
    set_cdb(7'd7, 32'hC0DE);
    step();
    clr_cdb();
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({issue_valid, issue_robid} !== {1'b1, 7'(i)}) begin
        bad++;
        $display("FAIL order_rev%0d_%0d: got v=%b robid=%0d required v=1 robid=%0d", reverse, i, issue_valid, issue_robid, i);
      end
    end
    step();
  endtask

  task automatic test_stall_hold();
    alu_stall = 1'b1;
    set_write(5'd8, 7'd70, 6'd4, 1'b1, 32'h70, 1'b1, 32'h71, 32'h72);
    sb_push(5'd8, 7'd70, 6'd4, 32'h70, 32'h71, 32'h72);
    step();
    set_write(5'd8, 7'd71, 6'd5, 1'b1, 32'h80, 1'b1, 32'h81, 32'h82);
    sb_push(5'd8, 7'd71, 6'd5, 32'h80, 32'h81, 32'h82);
    step();
    clr_write();
    total++; if ({issue_valid, issue_robid} !== {1'b1, 7'd70}) begin bad++; $display("FAIL hold_load: got v=%b robid=%0d required v=1 robid=70", issue_valid, issue_robid); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({issue_valid, issue_robid, issue_op1, issue_imm} !== {1'b1, 7'd70, 32'h70, 32'h72}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got v=%b robid=%0d op1=%h imm=%h required v=1 robid=70 op1=70 imm=72", c, issue_valid, issue_robid, issue_op1, issue_imm);
      end
    end
    alu_stall = 1'b0;
    step();
    total++; if ({issue_valid, issue_robid} !== {1'b1, 7'd71}) begin bad++; $display("FAIL hold_release: got v=%b robid=%0d required v=1 robid=71", issue_valid, issue_robid); end
    step();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL hold_empty: got=%b required=0", issue_valid); end
  endtask

  task automatic test_flush();
    alu_stall = 1'b1;
    set_write(5'd9, 7'd84, 6'd6, 1'b1, 32'd1, 1'b1, 32'd2, 32'd3);
    sb_push(5'd9, 7'd84, 6'd6, 32'd1, 32'd2, 32'd3);
    step();
    for (int i = 0; i < 4; i++) begin
      set_write(5'd9, 7'(80 + i), 6'(i), 1'b0, 32'(100 + i), 1'b1, 32'd0, 32'd0);
      step();
    end
    clr_write();
    total++; if ({issue_valid, issue_robid} !== {1'b1, 7'd84}) begin bad++; $display("FAIL flush_pre: got v=%b robid=%0d required v=1 robid=84", issue_valid, issue_robid); end
    rob_flush = 1'b1;
    set_write(5'd9, 7'd85, 6'd7, 1'b1, 32'd5, 1'b1, 32'd6, 32'd0);
    set_cdb(7'd100, 32'h5555);
    step();
    rob_flush = 1'b0;
    clr_write();
    clr_cdb();
    alu_stall = 1'b0;
    sb_q.delete();
    total++; if ({issue_valid, exers_stall} !== 2'b00) begin bad++; $display("FAIL flush_clear: got v=%b stall=%b required 0,0", issue_valid, exers_stall); end
    total++; if ({issue_robid, issue_op1} !== 39'd0) begin bad++; $display("FAIL flush_zero: got robid=%0d op1=%h required 0", issue_robid, issue_op1); end
    for (int t = 100; t < 104; t++) begin
      set_cdb(7'(t), 32'h6000 + 32'(t));
      step();
    end
    clr_cdb();
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d: got v=%b robid=%0d required v=0", c, issue_valid, issue_robid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_oldest_first(1'b0);
    test_oldest_first(1'b1);
    test_stall_hold();
    test_flush();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got pending=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
